// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Brief    : Shared types and constants for the shift-add multiplier
//             controller, its datapath and its bench.
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

    // Operand width used when no override is given.
    localparam int c_DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } mult_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_control_if
//  Brief    : Request/control bundle between the multiplier controller
//             (slave) and the datapath/requester side (master).
//  Revision : 1.0  initial release
// ============================================================================
interface mult_control_if #(
    parameter int WIDTH = mult_pkg::c_DEFAULT_WIDTH
);
    // Requests and datapath feedback into the controller.
    logic Run;
    logic ClearA_LoadB;
    logic M;

    // Datapath controls out of the controller.
    logic Clr_AX;
    logic Ld_B;
    logic Ld_AX;
    logic Add_En;
    logic Sub;
    logic Shift_En;
    logic Busy;
    logic Done;

    // Iteration count, exposed for observation only.
    logic [$clog2(WIDTH)-1:0] Cnt;

    modport master (
        output Run, ClearA_LoadB, M,
        input  Clr_AX, Ld_B, Ld_AX, Add_En, Sub, Shift_En, Busy, Done, Cnt
    );

    modport slave (
        input  Run, ClearA_LoadB, M,
        output Clr_AX, Ld_B, Ld_AX, Add_En, Sub, Shift_En, Busy, Done, Cnt
    );

endinterface : mult_control_if
`default_nettype wire

// File: rtl/mult_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_iter_counter
//  Brief    : Iteration counter 0..WIDTH-1 with clear, saturating increment
//             and terminal flag.
//  Revision : 1.0  initial release
// ============================================================================
module mult_iter_counter #(
    parameter int WIDTH = mult_pkg::c_DEFAULT_WIDTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     clr_i,
    input  wire logic                     inc_i,
    output logic [$clog2(WIDTH)-1:0]      cnt_o,
    output logic                          last_o
);

    localparam int                CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; the count never wraps past the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !last_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, forced to zero by reset at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == c_LAST);

endmodule : mult_iter_counter
`default_nettype wire

// File: rtl/mult_control.sv
`default_nettype none
// ============================================================================
//  Module   : mult_control
//  Brief    : Control FSM for a signed shift-add multiplier. Sequences
//             clear, WIDTH add/shift iterations (last one subtracts) and a
//             Done hold state. Busy/Shift_En/Done are registered; the load
//             and add strobes are decoded live because they follow Run,
//             ClearA_LoadB and the multiplier LSB M within the cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mult_control
    import mult_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mult_control_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);

    mult_state_t       state_q;
    mult_state_t       state_d;
    logic              busy_q;
    logic              shift_en_q;
    logic              done_q;

    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_last;
    logic [CNT_W-1:0]  cnt;

    logic              clr_ax;
    logic              ld_b;
    logic              ld_ax;
    logic              add_en;
    logic              sub;

    // Counter restarts when a multiply is accepted and advances after each
    // shift that is not the final one.
    assign cnt_clr = (state_q == IDLE) && bus.Run;
    assign cnt_inc = (state_q == SHIFT);

    mult_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Run) state_d = CLR;
            CLR:     state_d = ADD;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = cnt_last ? DONE : ADD;
            DONE:    if (!bus.Run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus outputs registered from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            shift_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d == CLR) || (state_d == ADD) || (state_d == SHIFT);
            shift_en_q <= (state_d == SHIFT);
            done_q     <= (state_d == DONE);
        end
    end

    // Live strobes: operand load in IDLE (Run has priority), clear in CLR,
    // conditional add in ADD with subtract on the sign-bit iteration.
    always_comb begin
        clr_ax = 1'b0;
        ld_b   = 1'b0;
        ld_ax  = 1'b0;
        add_en = 1'b0;
        sub    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.Run && bus.ClearA_LoadB) begin
                    ld_b   = 1'b1;
                    clr_ax = 1'b1;
                end
            end
            CLR: clr_ax = 1'b1;
            ADD: begin
                add_en = bus.M;
                ld_ax  = bus.M;
                sub    = bus.M && cnt_last;
            end
            default: ;
        endcase
    end

    assign bus.Clr_AX   = clr_ax;
    assign bus.Ld_B     = ld_b;
    assign bus.Ld_AX    = ld_ax;
    assign bus.Add_En   = add_en;
    assign bus.Sub      = sub;
    assign bus.Shift_En = shift_en_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Cnt      = cnt;

endmodule : mult_control
`default_nettype wire

// File: tb/tb_mult_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_control
//  Brief    : Bench for mult_control with a behavioural X:A:B datapath.
//             Directed operand pairs push hand-computed products into a
//             queue; a monitor pops and compares on every Done rise.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_control;
    import mult_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] a;      // multiplicand, presented on the switches during the run
        logic [31:0] b;      // multiplier, loaded into B
        logic [63:0] p;      // expected signed product
        int          adds;   // expected Add_En pulses (set bits of b)
        bit          hold;   // keep Run high through DONE
        bit          both;   // raise ClearA_LoadB together with Run
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sw    = '0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic        X     = 1'b0;

    int          checks     = 0;
    int          passed     = 0;
    int          add_cnt    = 0;
    int          sub_cnt    = 0;
    int          shift_cnt  = 0;
    int          busy_cnt   = 0;
    int          done_rises = 0;
    logic        done_prev  = 1'b0;
    logic [63:0] exp_q[$];
    vec_t        vecs[9];

    mult_control_if #(.WIDTH(W)) bus_if ();

    mult_control #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    assign bus_if.M = B[0];

    // Datapath: 33-bit signed add/sub into X:A, arithmetic shift of X:A:B.
    always @(posedge clk) begin
        logic [32:0] sum;
        sum = bus_if.Sub ? ({A[31], A} - {sw[31], sw}) : ({A[31], A} + {sw[31], sw});
        if (bus_if.Ld_B) B <= sw;
        if (bus_if.Clr_AX) begin
            A <= '0;
            X <= 1'b0;
        end else if (bus_if.Ld_AX) begin
            X <= sum[32];
            A <= sum[31:0];
        end else if (bus_if.Shift_En) begin
            A <= {X, A[31:1]};
            B <= {A[0], B[31:1]};
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] outs();
        return {bus_if.Clr_AX, bus_if.Ld_B, bus_if.Ld_AX, bus_if.Add_En,
                bus_if.Sub, bus_if.Shift_En, bus_if.Busy, bus_if.Done};
    endfunction

    // Monitor: per-cycle strobe counts and scoreboard compare on Done rise.
    always @(negedge clk) begin
        logic [63:0] exp_p;
        if (bus_if.Add_En)                add_cnt++;
        if (bus_if.Add_En && bus_if.Sub)  sub_cnt++;
        if (bus_if.Shift_En)              shift_cnt++;
        if (bus_if.Busy)                  busy_cnt++;
        if (bus_if.Done && !done_prev) begin
            done_rises++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected_done: Done rose with product 0x%0h, no multiply pending", {A, B});
            end else begin
                exp_p = exp_q.pop_front();
                check("sb_product", {A, B}, exp_p);
            end
        end
        done_prev = bus_if.Done;
    end

    // One complete multiply: load B, run, check latency and strobe counts.
    task automatic do_mult(input int idx);
        vec_t v;
        int   edges;
        v = vecs[idx];
        @(negedge clk); #1;
        sw = v.b;
        bus_if.ClearA_LoadB = 1'b1;
        @(negedge clk); #1;
        bus_if.ClearA_LoadB = v.both;
        sw = v.a;
        add_cnt = 0; sub_cnt = 0; shift_cnt = 0; busy_cnt = 0;
        bus_if.Run = 1'b1;
        exp_q.push_back(v.p);
        if (v.both) begin
            #1;
            check("run_priority_outs", {56'd0, outs()}, 64'd0);
        end
        // Edges counted with the Run-sampling edge as edge 1.
        edges = 0;
        while (!bus_if.Done && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk); #1;
            if (!v.hold) bus_if.Run = 1'b0;
        end
        check("latency_edges", 64'(edges), 64'(2 * W + 2));
        check("add_pulses",    64'(add_cnt), 64'(v.adds));
        check("sub_pulses",    64'(sub_cnt), 64'(v.b[31]));
        check("shift_pulses",  64'(shift_cnt), 64'(W));
        check("busy_cycles",   64'(busy_cnt), 64'(2 * W + 1));
        bus_if.ClearA_LoadB = 1'b0;
        if (v.hold) begin
            repeat (10) begin
                @(negedge clk); #1;
                check("done_held", {62'd0, bus_if.Done, bus_if.Busy}, 64'd2);
            end
            bus_if.Run = 1'b0;
            @(negedge clk); #1;
            check("release_to_idle", {56'd0, outs()}, 64'd0);
        end else begin
            @(negedge clk); #1;
            check("idle_after_done", {56'd0, outs()}, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int rises_before;
        int guard;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F,  2, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6,  2, 1'b0, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 32, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000,  1, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000,  1, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_3039, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_9F8E, 31, 1'b0, 1'b0};
        vecs[6] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000,  1, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, 13, 1'b0, 1'b0};
        vecs[8] = '{32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000,  0, 1'b0, 1'b0};

        bus_if.Run = 1'b0;
        bus_if.ClearA_LoadB = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", {56'd0, outs()}, 64'd0);
        check("reset_cnt",  64'(bus_if.Cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_reset_outs", {56'd0, outs()}, 64'd0);

        // Load request held for three cycles: only Ld_B and Clr_AX.
        sw = 32'h0000_1234;
        bus_if.ClearA_LoadB = 1'b1;
        repeat (3) begin
            #1;
            check("load_outs", {56'd0, outs()}, 64'h00C0);
            @(negedge clk); #1;
        end
        bus_if.ClearA_LoadB = 1'b0;
        #1;
        check("load_released", {56'd0, outs()}, 64'd0);
        check("load_b_value", {32'd0, B}, 64'h0000_1234);

        for (int i = 0; i < 9; i++) do_mult(i);

        // Reset asserted mid-cycle while cnt is 17: abort with no Done.
        @(negedge clk); #1;
        sw = 32'h0000_0007;
        bus_if.ClearA_LoadB = 1'b1;
        @(negedge clk); #1;
        bus_if.ClearA_LoadB = 1'b0;
        sw = 32'h0000_0005;
        shift_cnt = 0;
        rises_before = done_rises;
        bus_if.Run = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        bus_if.Run = 1'b0;
        guard = 0;
        while (shift_cnt < 17 && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        check("abort_shift_count", 64'(shift_cnt), 64'd17);
        @(posedge clk); #1;
        check("abort_cnt_before", 64'(bus_if.Cnt), 64'd17);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outs_async", {56'd0, outs()}, 64'd0);
        check("abort_cnt_async",  64'(bus_if.Cnt), 64'd0);
        repeat (2) begin
            @(negedge clk); #1;
            check("abort_outs_held", {56'd0, outs()}, 64'd0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("abort_idle_outs", {56'd0, outs()}, 64'd0);
        check("abort_no_done", 64'(done_rises), 64'(rises_before));

        // Fresh multiply after the abort.
        do_mult(3);

        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("done_rise_count", 64'(done_rises), 64'd10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule : tb_mult_control
`default_nettype wire

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter WIDTH, default 32, operand width and iteration count; legal range 2..64.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset_n  input  1  reset; asynchronous, active-low.
REQ-004 Run  input  1  start request, level-sampled in IDLE.
REQ-005 ClearA_LoadB  input  1  load-operand request, honoured only in IDLE.
REQ-006 M  input  1  current multiplier LSB, B[0] of the shift register.
REQ-007 Clr_AX  output  1  clear A accumulator and sign-extension bit X.
REQ-008 Ld_B  output  1  load multiplier register B from Switches.
REQ-009 Ld_AX  output  1  capture adder sum into A and adder sign output into X.
REQ-010 Add_En  output  1  drives adder outputEnable.
REQ-011 Sub  output  1  drives adder sub, which makes the adder compute A minus Switches.
REQ-012 Shift_En  output  1  arithmetic right shift of the X:A:B chain.
REQ-013 Busy  output  1  operation in progress.
REQ-014 Done  output  1  product valid in A:B.

Function
REQ-015 FSM states SHALL be IDLE, CLR, ADD, SHIFT and DONE; an iteration counter cnt SHALL count 0..WIDTH-1.
REQ-016 IDLE: Run=1 -> CLR with cnt=0; otherwise stay in IDLE.
REQ-017 CLR -> ADD unconditionally; Clr_AX=1 for that one cycle.
REQ-018 ADD -> SHIFT unconditionally; Add_En=Ld_AX=M; Sub=M AND (cnt==WIDTH-1), so the last iteration subtracts for two's-complement sign.
REQ-019 SHIFT: Shift_En=1; if cnt==WIDTH-1 -> DONE, else cnt+1 and -> ADD.
REQ-020 DONE: Done=1; stay while Run=1; Run=0 -> IDLE, so one Run assertion yields one multiply.
REQ-021 Busy=1 in CLR, ADD and SHIFT only.
REQ-022 Latency: Done SHALL rise 2*WIDTH+2 rising edges after the edge that samples Run=1 in IDLE (66 for WIDTH=32).
REQ-023 IDLE with ClearA_LoadB=1 and Run=0: Ld_B=1 and Clr_AX=1, combinationally, for as long as the request is held.
REQ-024 IDLE with Run=1 and ClearA_LoadB=1: Run has priority, Ld_B=0, and the FSM enters CLR.
REQ-025 Run deasserted mid-operation SHALL be ignored; ClearA_LoadB outside IDLE SHALL be ignored.
REQ-026 Outputs not named for a state SHALL be 0; at most one of Ld_B, Ld_AX and Shift_En is high in any cycle.
REQ-027 cnt SHALL NOT wrap; it is held at WIDTH-1 in DONE and cleared on entry to CLR.

Reset
REQ-028 Reset_n=0 SHALL force IDLE and cnt=0 immediately, regardless of Clk.
REQ-029 During and after reset, every output SHALL be 0 until a new request arrives.
REQ-030 Reset mid-operation SHALL abort the operation with no Done pulse; a later Run starts a fresh multiply.

Structure
REQ-031 Package mult_pkg SHALL hold the state enum type mult_state_t and the default WIDTH constant, shared with the datapath and the bench.
REQ-032 Sub-module mult_iter_counter SHALL provide cnt, clear, increment and a terminal flag (cnt==WIDTH-1); the FSM and output decode stay in mult_control.

Verification
REQ-033 Reset, then hold ClearA_LoadB=1 with Run=0 for 3 cycles -> Ld_B=1 and Clr_AX=1 for exactly those 3 cycles; no other output high.
REQ-034 Run=1 with M tied to 0 -> Add_En never asserted; 32 Shift_En pulses; Done rises at edge 66; Busy=1 for 65 cycles.
REQ-035 M=1 only during the final ADD (B=0x80000000 pattern) -> exactly one Add_En, and it has Sub=1; the result matches the signed product.
REQ-036 Run held high through DONE for 10 cycles -> Done stays 1 and no restart; Run=0 -> IDLE on the next edge.
REQ-037 Reset_n pulsed low at cnt=17 asynchronously, mid-cycle -> outputs 0 immediately, state IDLE, no Done; the next Run completes with the correct 66-cycle latency.
REQ-038 Random signed operand pairs (including 0x7FFFFFFF*0x80000000 and -1*-1) -> A:B matches the 64-bit signed reference product.
